pipelined_prefix_adder: RTL and testbench

Parametrised, pipelined Kogge-Stone prefix adder/subtractor with valid/ready handshakes on both sides. It generalises the 16-bit combinational prefix adder in three ways: any power-of-two width, configurable prefix levels per pipeline stage, and a runtime add/sub mode with signed-overflow and zero flags. It sits between operand-producing and result-consuming pipeline stages in datapath exercises and sustains one operation per cycle.

---
 rtl/pipelined_prefix_adder_pkg.sv | 29 ++
 rtl/pipelined_prefix_adder_if.sv | 27 ++
 rtl/pipelined_prefix_adder_level.sv | 20 ++
 rtl/pipelined_prefix_adder.sv | 135 +++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Kogge-Stone adder.
package prefix_adder_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  function automatic int unsigned log2w(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n; v > 1; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int unsigned num_prefix_stages(input int unsigned w, input int unsigned lps);
    return (log2w(w) + lps - 1) / lps;
  endfunction

  function automatic int unsigned pipe_latency(input int unsigned w, input int unsigned lps);
    return num_prefix_stages(w, lps) + 2;
  endfunction

endpackage

// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result handshake bundle; the adder takes the slave view.
interface pipelined_prefix_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport slave (
    input  in_valid, a, b, c_in, op_sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow, zero
  );

  modport master (
    output in_valid, a, b, c_in, op_sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow, zero
  );
endinterface

// File: rtl/pipelined_prefix_adder_level.sv
// One combinational Kogge-Stone level; index 0 holds the carry-in as bit -1.
module prefix_level
  import prefix_adder_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DISTANCE = 1
) (
  input  pg_t [WIDTH:0] pg_i,
  output pg_t [WIDTH:0] pg_o
);

  always_comb begin
    pg_o = pg_i;
    for (int unsigned j = DISTANCE; j <= WIDTH; j++) begin
      pg_o[j].g = pg_i[j].g | (pg_i[j].p & pg_i[j-DISTANCE].g);
      pg_o[j].p = pg_i[j].p & pg_i[j-DISTANCE].p;
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with per-stage valid bits and
// collapsing bubbles; in_ready is combinational through the valid chain.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned LEVELS_PER_STAGE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  pipelined_prefix_adder_if.slave   bus
);

  localparam int unsigned LOG2W = log2w(WIDTH);
  localparam int unsigned NPS   = num_prefix_stages(WIDTH, LEVELS_PER_STAGE);
  localparam int unsigned LAST  = NPS + 1;

  logic [LAST:0]    vld_q;
  logic [LAST:0]    load;
  pg_t  [WIDTH:0]   pg_q  [NPS+1];
  logic [WIDTH-1:0] p_q   [NPS+1];
  pg_t  [WIDTH:0]   lvl_o [LOG2W];
  pg_t  [WIDTH:0]   grp_d [NPS];
  pg_t  [WIDTH:0]   pg0_d;

  op_t              op;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH:0]   carry;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Stage k may load if any stage at or after it is empty, or the consumer takes the result.
  always_comb begin
    logic acc;
    load = '0;
    acc  = bus.out_ready;
    for (int unsigned i = 0; i <= LAST; i++) begin
      acc             = acc | ~vld_q[LAST-i];
      load[LAST-i]    = acc;
    end
  end

  always_comb begin
    op      = bus.op_sub ? OP_SUB : OP_ADD;
    b_eff   = (op == OP_SUB) ? ~bus.b : bus.b;
    cin_eff = (op == OP_SUB) ? 1'b1 : bus.c_in;
    pg0_d   = '0;
    pg0_d[0].p = 1'b0;
    pg0_d[0].g = cin_eff;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pg0_d[i+1].p = bus.a[i] ^ b_eff[i];
      pg0_d[i+1].g = bus.a[i] & b_eff[i];
    end
  end

  for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
    pg_t [WIDTH:0] lvl_in;
    if ((k % LEVELS_PER_STAGE) == 0) begin : g_from_reg
      assign lvl_in = pg_q[k / LEVELS_PER_STAGE];
    end else begin : g_from_lvl
      assign lvl_in = lvl_o[k-1];
    end
    prefix_level #(
      .WIDTH    (WIDTH),
      .DISTANCE (1 << k)
    ) u_level (
      .pg_i (lvl_in),
      .pg_o (lvl_o[k])
    );
  end

  for (genvar s = 1; s <= NPS; s++) begin : g_grp
    localparam int unsigned TOP = ((s * LEVELS_PER_STAGE) < LOG2W) ? (s * LEVELS_PER_STAGE) : LOG2W;
    assign grp_d[s-1] = lvl_o[TOP-1];
  end

  // Position WIDTH spans only bits W-1..0 after LOG2W levels, so fold the carry-in
  // once more; lower positions already include it and have P=0.
  always_comb begin
    carry = '0;
    for (int unsigned j = 0; j <= WIDTH; j++) begin
      carry[j] = pg_q[NPS][j].g | (pg_q[NPS][j].p & pg_q[NPS][0].g);
    end
    sum_d   = p_q[NPS] ^ carry[WIDTH-1:0];
    c_out_d = carry[WIDTH];
    ovf_d   = carry[WIDTH-1] ^ carry[WIDTH];
    zero_d  = (sum_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int unsigned s = 0; s <= NPS; s++) begin
        pg_q[s] <= '0;
        p_q[s]  <= '0;
      end
    end else begin
      if (load[0]) vld_q[0] <= bus.in_valid;
      if (load[0] && bus.in_valid) begin
        pg_q[0] <= pg0_d;
        p_q[0]  <= bus.a ^ b_eff;
      end
      for (int unsigned s = 1; s <= NPS; s++) begin
        if (load[s]) vld_q[s] <= vld_q[s-1];
        if (load[s] && vld_q[s-1]) begin
          pg_q[s] <= grp_d[s-1];
          p_q[s]  <= p_q[s-1];
        end
      end
      if (load[LAST]) vld_q[LAST] <= vld_q[NPS];
      if (load[LAST] && vld_q[NPS]) begin
        sum_q   <= sum_d;
        c_out_q <= c_out_d;
        ovf_q   <= ovf_d;
        zero_q  <= zero_d;
      end
    end
  end

  assign bus.in_ready  = load[0] & ~rst;
  assign bus.out_valid = vld_q[LAST];
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench for three adder configurations (32/2, 16/1, 64/3).
module tb_pipelined_prefix_adder;

  typedef struct {
    logic [63:0] sum;
    logic        c;
    logic        v;
    logic        z;
    int          t;
    logic        lat;
  } res_t;

  logic clk;
  logic rst;

  int unsigned WID [3] = '{32, 16, 64};
  int          LAT [3] = '{5, 6, 4};

  logic [63:0] d_a   [3];
  logic [63:0] d_b   [3];
  logic        d_cin [3];
  logic        d_sub [3];
  logic        d_iv  [3];
  logic        d_or  [3];
  res_t        d_exp [3];

  logic        o_v   [3];
  logic        o_ir  [3];
  logic        o_c   [3];
  logic        o_ov  [3];
  logic        o_z   [3];
  logic [63:0] o_sum [3];
  logic        acc   [3];
  logic        held  [3];
  logic [71:0] held_val [3];
  int          nout  [3];

  res_t q0[$];
  res_t q1[$];
  res_t q2[$];

  int unsigned n_vec;
  int unsigned n_miss;
  int          cyc;

  pipelined_prefix_adder_if #(.WIDTH(32)) if0 ();
  pipelined_prefix_adder_if #(.WIDTH(16)) if1 ();
  pipelined_prefix_adder_if #(.WIDTH(64)) if2 ();

  assign if0.in_valid = d_iv[0];  assign if0.a = d_a[0][31:0]; assign if0.b = d_b[0][31:0];
  assign if0.c_in = d_cin[0];     assign if0.op_sub = d_sub[0]; assign if0.out_ready = d_or[0];
  assign if1.in_valid = d_iv[1];  assign if1.a = d_a[1][15:0]; assign if1.b = d_b[1][15:0];
  assign if1.c_in = d_cin[1];     assign if1.op_sub = d_sub[1]; assign if1.out_ready = d_or[1];
  assign if2.in_valid = d_iv[2];  assign if2.a = d_a[2];       assign if2.b = d_b[2];
  assign if2.c_in = d_cin[2];     assign if2.op_sub = d_sub[2]; assign if2.out_ready = d_or[2];

  pipelined_prefix_adder #(.WIDTH(32), .LEVELS_PER_STAGE(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  pipelined_prefix_adder #(.WIDTH(16), .LEVELS_PER_STAGE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  pipelined_prefix_adder #(.WIDTH(64), .LEVELS_PER_STAGE(3)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    logic [63:0] mask, am, bm;
    logic [64:0] full;
    logic ci;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = (sub ? ~b : b) & mask;
    ci   = sub ? 1'b1 : cin;
    full = {1'b0, am} + {1'b0, bm} + {64'd0, ci};
    r.sum = full[63:0] & mask;
    r.c   = full[w];
    r.v   = (am[w-1] == bm[w-1]) && (r.sum[w-1] != am[w-1]);
    r.z   = (r.sum == 64'd0);
    r.t   = 0;
    r.lat = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic res_t qpop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int d, input res_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic set_rand(input int d);
    d_a[d]   = {$urandom, $urandom};
    d_b[d]   = {$urandom, $urandom};
    d_cin[d] = 1'($urandom_range(0, 1));
    d_sub[d] = 1'($urandom_range(0, 1));
    d_exp[d] = model(WID[d], d_a[d], d_b[d], d_cin[d], d_sub[d]);
  endtask

  task automatic set_beat(input int d, input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic sub, input logic [63:0] es, input logic ec, input logic ev,
                          input logic ez);
    d_a[d] = a; d_b[d] = b; d_cin[d] = cin; d_sub[d] = sub;
    d_exp[d].sum = es; d_exp[d].c = ec; d_exp[d].v = ev; d_exp[d].z = ez;
    d_exp[d].t = 0; d_exp[d].lat = 1'b1;
  endtask

  // One clock: sample at negedge, score outputs, record acceptance, advance past posedge.
  task automatic cycle();
    res_t e;
    logic [71:0] obs;
    @(negedge clk);
    cyc++;
    o_v[0] = if0.out_valid; o_ir[0] = if0.in_ready; o_c[0] = if0.c_out;
    o_ov[0] = if0.overflow; o_z[0] = if0.zero; o_sum[0] = 64'(if0.sum);
    o_v[1] = if1.out_valid; o_ir[1] = if1.in_ready; o_c[1] = if1.c_out;
    o_ov[1] = if1.overflow; o_z[1] = if1.zero; o_sum[1] = 64'(if1.sum);
    o_v[2] = if2.out_valid; o_ir[2] = if2.in_ready; o_c[2] = if2.c_out;
    o_ov[2] = if2.overflow; o_z[2] = if2.zero; o_sum[2] = if2.sum;
    for (int d = 0; d < 3; d++) begin
      acc[d] = 1'b0;
      if (rst) begin
        held[d] = 1'b0;
        continue;
      end
      obs = {4'd0, o_v[d], o_c[d], o_ov[d], o_z[d], o_sum[d]};
      if (held[d]) chk($sformatf("dut%0d_stall_hold", d), obs, held_val[d]);
      held[d]     = o_v[d] && !d_or[d];
      held_val[d] = obs;
      if (o_v[d] && d_or[d]) begin
        nout[d]++;
        if (qsize(d) == 0) begin
          chk($sformatf("dut%0d_unexpected_out", d), 72'(o_v[d]), 72'd0);
        end else begin
          e = qpop(d);
          chk($sformatf("dut%0d_sum", d), 72'(o_sum[d]), 72'(e.sum));
          chk($sformatf("dut%0d_c_out", d), 72'(o_c[d]), 72'(e.c));
          chk($sformatf("dut%0d_overflow", d), 72'(o_ov[d]), 72'(e.v));
          chk($sformatf("dut%0d_zero", d), 72'(o_z[d]), 72'(e.z));
          if (e.lat) chk($sformatf("dut%0d_latency", d), 72'(cyc - e.t), 72'(LAT[d]));
        end
      end
      acc[d] = d_iv[d] && o_ir[d];
      if (acc[d]) begin
        e   = d_exp[d];
        e.t = cyc;
        qpush(d, e);
      end
    end
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    d_iv[d] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc[d]) break;
    end
    chk($sformatf("dut%0d_accept", d), 72'(acc[d]), 72'd1);
    d_iv[d] = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (q0.size() + q1.size() + q2.size() == 0) break;
      cycle();
    end
    chk("drain_empty", 72'(q0.size() + q1.size() + q2.size()), 72'd0);
  endtask

  initial begin
    int base, sent, stall_left, drop_cyc, fell_cyc;
    int sent1, sent2;
    logic dropped, fell;
    n_vec = 0; n_miss = 0; cyc = 0;
    for (int d = 0; d < 3; d++) begin
      d_a[d] = '0; d_b[d] = '0; d_cin[d] = 1'b0; d_sub[d] = 1'b0;
      d_iv[d] = 1'b0; d_or[d] = 1'b1; held[d] = 1'b0; nout[d] = 0; acc[d] = 1'b0;
      d_exp[d] = model(WID[d], 64'd0, 64'd0, 1'b0, 1'b0);
    end

    // Reset with a beat presented throughout; it must not be taken.
    rst = 1'b1;
    set_beat(0, 64'h5, 64'h6, 1'b0, 1'b0, 64'hB, 1'b0, 1'b0, 1'b0);
    d_iv[0] = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    d_iv[0] = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 72'(if0.out_valid), 72'd0);
    chk("rst_sum", 72'(if0.sum), 72'd0);
    chk("rst_flags", 72'({if0.c_out, if0.overflow, if0.zero}), 72'd0);
    chk("rst_in_ready", 72'(if0.in_ready), 72'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) cycle();
    chk("rst_nothing_accepted", 72'(nout[0]), 72'd0);

    // Directed boundary beats, each with exact-latency check.
    set_beat(0, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    send(0);
    drain(20);
    set_beat(0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 1'b0);
    send(0);
    set_beat(0, 64'h8000_0000, 64'h1, 1'b1, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    send(0);
    set_beat(0, 64'h1234_5678, 64'h1234_5678, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1);
    send(0);
    set_beat(0, 64'h1, 64'h2, 1'b1, 1'b0, 64'h4, 1'b0, 1'b0, 1'b0);
    send(0);
    drain(30);

    // Back-to-back stream of 20 with a 7-cycle consumer stall after the 3rd result.
    base = nout[0]; sent = 0; stall_left = 0; drop_cyc = 0; fell_cyc = 0;
    dropped = 1'b0; fell = 1'b0;
    set_rand(0);
    d_iv[0] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (sent >= 20 && q0.size() == 0) break;
      cycle();
      if (acc[0]) begin
        sent++;
        if (sent < 20) set_rand(0);
        else d_iv[0] = 1'b0;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (!o_ir[0] && !fell) begin
          fell = 1'b1;
          fell_cyc = cyc;
        end
        if (stall_left == 0) d_or[0] = 1'b1;
      end else if (!dropped && (nout[0] - base) >= 3) begin
        dropped = 1'b1;
        d_or[0] = 1'b0;
        stall_left = 7;
        drop_cyc = cyc + 1;
      end
    end
    d_iv[0] = 1'b0;
    d_or[0] = 1'b1;
    chk("bp_in_ready_fell_in_5", 72'(fell && (fell_cyc - drop_cyc) < 5), 72'd1);
    chk("bp_result_count", 72'(nout[0] - base), 72'd20);
    drain(20);

    // Three beats in flight, then a one-cycle reset pulse.
    sent = 0;
    set_rand(0);
    d_iv[0] = 1'b1;
    for (int i = 0; i < 20 && sent < 3; i++) begin
      cycle();
      if (acc[0]) begin
        sent++;
        set_rand(0);
      end
    end
    d_iv[0] = 1'b0;
    chk("mid_rst_beats_sent", 72'(sent), 72'd3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 72'(if0.out_valid), 72'd0);
    @(posedge clk);
    #1;
    base = nout[0];
    for (int i = 0; i < 10; i++) cycle();
    chk("mid_rst_no_stale", 72'(nout[0] - base), 72'd0);

    // Random sweep on the 16/1 and 64/3 configurations.
    sent1 = 0; sent2 = 0;
    for (int i = 0; i < 20000; i++) begin
      if (sent1 >= 1000 && sent2 >= 1000 && q1.size() == 0 && q2.size() == 0) break;
      set_rand(1);
      set_rand(2);
      d_iv[1] = (sent1 < 1000) && ($urandom_range(0, 3) != 0);
      d_iv[2] = (sent2 < 1000) && ($urandom_range(0, 3) != 0);
      d_or[1] = ($urandom_range(0, 3) != 0);
      d_or[2] = ($urandom_range(0, 3) != 0);
      cycle();
      if (acc[1]) sent1++;
      if (acc[2]) sent2++;
    end
    d_iv[1] = 1'b0; d_iv[2] = 1'b0;
    d_or[1] = 1'b1; d_or[2] = 1'b1;
    chk("sweep16_sent", 72'(sent1), 72'd1000);
    chk("sweep64_sent", 72'(sent2), 72'd1000);
    drain(20);
    for (int i = 0; i < 5; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
